// File: rtl/array_sp_mask_ext.sv
// Single-port SRAM behavioural model with per-lane write mask, configurable
// read latency with a read-valid strobe, and an optional post-reset clear pass.
module array_sp_mask_ext #(
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 16384,
    parameter int LANES      = 1,
    parameter int LANE_W     = 64,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                     RW0_clk,
    input  logic                     RW0_reset,
    input  logic [ADDR_W-1:0]        RW0_addr,
    input  logic                     RW0_en,
    input  logic                     RW0_wmode,
    input  logic [LANES-1:0]         RW0_wmask,
    input  logic [LANES*LANE_W-1:0]  RW0_wdata,
    output logic [LANES*LANE_W-1:0]  RW0_rdata,
    output logic                     RW0_rvalid,
    output logic                     RW0_ready
);

    localparam int                W       = LANES * LANE_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_we;
    logic                ready;

    logic [W-1:0]        mem [DEPTH];
    logic                in_range;
    logic                acc_wr;
    logic                acc_rd;
    logic [W-1:0]        rd_word;

    logic [RD_LAT-1:0]   vld_q;
    logic [W-1:0]        dat_q [RD_LAT];

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_C) begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        clr_we = 1'b0;
        case (state_q)
            ST_CLEAR: clr_we = 1'b1;
            ST_READY: ready  = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------- access decode
    assign in_range = ({1'b0, RW0_addr} < DEPTH_C);
    assign acc_wr   = RW0_en && ready &&  RW0_wmode;
    assign acc_rd   = RW0_en && ready && !RW0_wmode;
    // Out-of-range reads return zero rather than whatever the index aliases to.
    assign rd_word  = in_range ? mem[RW0_addr] : '0;

    // --------------------------------------------------------------- array
    // NOTE: the storage array has no reset; zeroing it is the clear
    // sequencer's job, which keeps the array mappable onto real SRAM.
    always_ff @(posedge RW0_clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (acc_wr && in_range) begin
            for (int k = 0; k < LANES; k++) begin
                if (RW0_wmask[k]) begin
                    mem[RW0_addr][k*LANE_W +: LANE_W] <= RW0_wdata[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    // -------------------------------------------------------- read pipeline
    // Data stages only load when a valid beat arrives, so the last stage
    // holds the most recent result while rvalid is low.
    always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= acc_rd;
            if (acc_rd) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign RW0_rvalid = vld_q[RD_LAT-1];
    assign RW0_rdata  = dat_q[RD_LAT-1];
    assign RW0_ready  = ready;

endmodule

// File: tb/tb_array_sp_mask_ext.sv
// Scoreboard bench for array_sp_mask_ext: reads push expected data and due
// cycle; a negedge monitor pops and compares whenever rvalid is seen.
module tb_array_sp_mask_ext;

    localparam int ADDR_W     = 4;
    localparam int DEPTH      = 12;
    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam int RD_LAT     = 2;
    localparam int INIT_CLEAR = 1;
    localparam int W          = LANES * LANE_W;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic [ADDR_W-1:0] addr  = '0;
    logic              en    = 1'b0;
    logic              wmode = 1'b0;
    logic [LANES-1:0]  wmask = '0;
    logic [W-1:0]      wdata = '0;
    logic [W-1:0]      rdata;
    logic              rvalid;
    logic              ready;

    array_sp_mask_ext #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .LANES     (LANES),
        .LANE_W    (LANE_W),
        .RD_LAT    (RD_LAT),
        .INIT_CLEAR(INIT_CLEAR)
    ) dut (
        .RW0_clk   (clk),
        .RW0_reset (rst),
        .RW0_addr  (addr),
        .RW0_en    (en),
        .RW0_wmode (wmode),
        .RW0_wmask (wmask),
        .RW0_wdata (wdata),
        .RW0_rdata (rdata),
        .RW0_rvalid(rvalid),
        .RW0_ready (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q [$];
    int           due_q [$];

    task automatic check(input bit ok, input string name,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read, on time.
    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_rvalid", rdata, '0);
            end else begin
                logic [W-1:0] e;
                int           d;
                e = exp_q.pop_front();
                d = due_q.pop_front();
                check(rdata === e, "read_data", rdata, e);
                check(cyc == d, "read_latency", W'(cyc), W'(d));
            end
        end
    end

    function automatic void flush_sb();
        exp_q.delete();
        due_q.delete();
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                            input logic [LANES-1:0] m);
        en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        @(negedge clk);
        en = 1'b0; wmode = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [W-1:0] e);
        en = 1'b1; wmode = 1'b0; addr = a;
        exp_q.push_back(e);
        due_q.push_back(cyc + RD_LAT);
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check(exp_q.size() == 0, "drain", W'(exp_q.size()), '0);
        flush_sb();
        @(negedge clk);
    endtask

    // Release reset and count cycles until ready. Optionally poke the array
    // mid-clear, or re-assert reset once the clear counter reaches abort_at.
    task automatic release_and_count(input bit poke, input int abort_at, output int n);
        n   = 0;
        rst = 1'b0;
        while (!ready && n < 100) begin
            if (n == abort_at) begin
                rst = 1'b1;
                flush_sb();
                return;
            end
            en = 1'b0; wmode = 1'b0;
            if (poke && n == 8) begin
                en = 1'b1; wmode = 1'b1; addr = 4'd2; wdata = 32'hDEADBEEF; wmask = 4'hF;
            end else if (poke && n == 9) begin
                en = 1'b1; addr = 4'd2;
            end
            @(negedge clk);
            n++;
        end
        en = 1'b0; wmode = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        repeat (3) @(negedge clk);
        check(ready == 1'b0,  "reset_ready",  W'(ready),  '0);
        check(rvalid == 1'b0, "reset_rvalid", W'(rvalid), '0);
        check(rdata == '0,    "reset_rdata",  rdata,      '0);

        release_and_count(1'b0, -1, n);
        check(n == DEPTH, "clear_cycles", W'(n), W'(DEPTH));

        for (int i = 0; i < DEPTH; i++) begin
            do_read(ADDR_W'(i), 32'h0000_0000);
        end
        drain();

        // Lane masking: lanes 0 and 2 overwritten by the second write.
        do_write(4'd5, 32'hAABBCCDD, 4'hF);
        do_write(4'd5, 32'h11223344, 4'h5);
        do_read(4'd5, 32'hAA22CC44);
        drain();

        do_write(4'd1, 32'h0000_0001, 4'hF);
        do_write(4'd2, 32'h0000_0002, 4'hF);
        do_write(4'd3, 32'h0000_0003, 4'hF);
        do_read(4'd1, 32'h0000_0001);
        do_read(4'd2, 32'h0000_0002);
        do_read(4'd3, 32'h0000_0003);
        drain();
        check(rvalid == 1'b0, "hold_rvalid", W'(rvalid), '0);
        check(rdata == 32'h0000_0003, "hold_rdata", rdata, 32'h0000_0003);

        do_write(4'd3, 32'hFFFF_FFFF, 4'h0);
        do_read(4'd3, 32'h0000_0003);
        drain();

        // Out-of-range address: write dropped, read returns zero.
        do_write(4'd13, 32'hFFFF_FFFF, 4'hF);
        do_read(4'd13, 32'h0000_0000);
        do_read(4'd1, 32'h0000_0001);
        drain();

        // Reset with a read in flight.
        do_write(4'd11, 32'h5A5A_5A5A, 4'hF);
        do_read(4'd5, 32'hAA22CC44);
        rst = 1'b1;
        flush_sb();
        @(negedge clk);
        check(rvalid == 1'b0, "inflight_discard", W'(rvalid), '0);
        check(rdata == '0, "inflight_rdata", rdata, '0);
        @(negedge clk);

        // Abort a clear at word 6, then the full restart must take DEPTH cycles.
        release_and_count(1'b0, 6, n);
        check(ready == 1'b0, "abort_ready", W'(ready), '0);
        repeat (2) @(negedge clk);
        release_and_count(1'b1, -1, n);
        check(n == DEPTH, "clear_restart", W'(n), W'(DEPTH));

        do_read(4'd5,  32'h0000_0000);
        do_read(4'd2,  32'h0000_0000);
        do_read(4'd11, 32'h0000_0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
